application_selector_id_eeprom_i2c_ctrl: RTL
============================================

# application_selector_id_eeprom_i2c_ctrl

Hardware I2C master for the board ID EEPROM. It sits on the same Avalon-MM fabric as the PIO peripherals and replaces CPU bit-banging of the EEPROM SCL/SDA lines with a byte-level sequencer. The CPU writes one command word to issue START, a byte transfer, ACK and STOP phases. Status and received data are read back from a separate register, with optional completion interrupt.

## Interface
- `DEFAULT_CLKDIV`, default 250: reset value of CLKDIV, in clk cycles per SCL half-period (100 kHz at 50 MHz).
- `clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: register select; 0 CMD, 1 STATUS, 2 CLKDIV, 3 reserved.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read mux, zero wait states; unused bits 0.
- `scl_oe` out 1: 1 drives SCL low; 0 releases it (pull-up).
- `sda_oe` out 1: 1 drives SDA low; 0 releases it.
- `sda_in` in 1: SDA pad level, already synchronised externally.
- `irq` out 1: `done & irq_en`.

## Operation
- **CMD (write only, reads 0).** Fields:
  - [0] START
  - [1] STOP
  - [2] WRITE
  - [3] READ
  - [4] ACK_OUT (0 = master ACK, 1 = NACK)
  - [15:8] TX byte
  - WRITE and READ both set: treat as WRITE.
  - Accepted only when `busy` = 0. While busy, the write is ignored and sticky `overrun` is set.
- **STATUS.** Fields:
  - [0] busy
  - [1] done (sticky)
  - [2] rx_nack
  - [3] overrun
  - [4] irq_en (RW)
  - [15:8] RX byte
  - Any write to STATUS clears done and overrun and loads irq_en from writedata[4].
- **CLKDIV.** [15:0] RW; half-period N = max(CLKDIV, 2).
- **FSM states:** IDLE, RSTART, START_A, START_B, BIT_LO, BIT_HI, ACK_LO, ACK_HI, STOP_A, STOP_B, STOP_C.
  - Every non-IDLE state lasts exactly N cycles, then advances.
- **Path from IDLE:**
  - START with SCL currently held low goes to RSTART (SCL low, SDA released).
  - START otherwise goes to START_A (both released), then START_B (SDA low, SCL released).
  - After the optional start, WRITE/READ enters BIT_LO. Otherwise the FSM goes to STOP_A if STOP is set, else back to IDLE.
  - STOP-only command from an idle bus (SCL released): executes STOP_A..STOP_C.
- **Data bits.** 8 iterations of BIT_LO then BIT_HI, MSB first.
  - BIT_LO: SCL low. For WRITE, SDA is set to the TX bit on the state's first cycle. For READ, SDA is released.
  - BIT_HI: SCL released. For READ, `sda_in` is shifted in on the last cycle.
- **ACK bit.**
  - ACK_LO/ACK_HI: for WRITE, SDA released and `sda_in` sampled at the end of ACK_HI into rx_nack.
  - For READ, SDA driven per ACK_OUT; rx_nack holds ACK_OUT.
- **Stop sequence.** STOP_A (SCL low, SDA low), STOP_B (SCL released, SDA low), STOP_C (both released).
- **Ending without STOP.** The FSM returns to IDLE with SCL driven low and SDA holding its last value (bus owned).
- **Completion.** On every return to IDLE, busy goes to 0 and done goes to 1.

## Timing
- **Reset values:**
  - `scl_oe` = 0, `sda_oe` = 0
  - FSM IDLE, bus released
  - busy, done, rx_nack, overrun, irq_en, RX = 0
  - CLKDIV = DEFAULT_CLKDIV
  - `irq` = 0
- **Command start.** `busy` reads 1 on the cycle after an accepted CMD write. Line outputs change from the same cycle.
- **Command latency** (write to busy = 0): 2N per START (3N with RSTART), 18N per byte, 3N per STOP.
- **CLKDIV writes.** A CLKDIV write during busy takes effect at the next phase boundary.
- **Simultaneous events.** A STATUS write coinciding with done being set leaves done = 1.
- **Reset mid-transfer.** Asynchronous reset mid-transfer releases both lines immediately. Software must recover the bus.

## Structure
- **Package `id_eeprom_i2c_pkg`** holds:
  - FSM state enum
  - register offsets
  - CMD/STATUS bit positions
  - CLKDIV minimum constant
- **Sub-module `id_eeprom_i2c_phase_timer`** is a 16-bit down-counter. Load N; assert `phase_end` on the last cycle.
- **Main module** owns:
  - FSM
  - 3-bit bit counter
  - TX/RX shift registers
  - register file

## Test plan
- CLKDIV = 4, CMD = START|WRITE|0xA0 with a slave model ACKing:
  - SDA falls while SCL high; 9 SCL pulses; bits on SDA are 1,0,1,0,0,0,0,0.
  - busy clears after 2×4 + 18×4 = 80 cycles; rx_nack = 0; done = 1.
- READ|STOP|ACK_OUT = 1 with the model returning 0x5A:
  - RX = 0x5A; SDA released during the 9th bit.
  - STOP edge: SDA rises while SCL high; both lines released at the end.
- Repeated start after a WRITE without STOP:
  - RSTART phase observed (SCL low, SDA released), then a normal START.
- Write to an unanswered address (no slave ACK):
  - rx_nack = 1.
- CMD write while busy:
  - No change on the bus; overrun = 1.
  - STATUS write clears overrun and done.
- irq_en = 1:
  - `irq` rises with done and falls on the STATUS write.
- Reset asserted mid-byte:
  - `scl_oe`/`sda_oe` go to 0 asynchronously; CLKDIV reads 250.

Source files
------------

// File: rtl/id_eeprom_i2c_pkg.sv
// Shared definitions for the board ID EEPROM I2C master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_eeprom_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RSTART,
        ST_START_A,
        ST_START_B,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_ACK_LO,
        ST_ACK_HI,
        ST_STOP_A,
        ST_STOP_B,
        ST_STOP_C
    } state_t;

    // Register offsets on the Avalon-MM slave
    localparam logic [1:0] REG_CMD    = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CLKDIV = 2'd2;

    // CMD field positions
    localparam int CMD_START  = 0;
    localparam int CMD_STOP   = 1;
    localparam int CMD_WRITE  = 2;
    localparam int CMD_READ   = 3;
    localparam int CMD_ACK    = 4;
    localparam int CMD_TX_LSB = 8;

    // STATUS field positions
    localparam int STS_BUSY    = 0;
    localparam int STS_DONE    = 1;
    localparam int STS_RX_NACK = 2;
    localparam int STS_OVERRUN = 3;
    localparam int STS_IRQ_EN  = 4;
    localparam int STS_RX_LSB  = 8;

    // Shortest legal SCL half-period in clk cycles
    localparam logic [15:0] CLKDIV_MIN = 16'd2;

    function automatic logic [15:0] half_period(input logic [15:0] div);
        return (div < CLKDIV_MIN) ? CLKDIV_MIN : div;
    endfunction

endpackage

// File: rtl/id_eeprom_i2c_phase_timer.sv
// Phase timer: 16-bit down-counter loaded with a phase length N, flags the phase's last cycle.
// Latency: o_phase_end is high on the Nth cycle after the load edge.
// Backpressure: none; a load restarts the count unconditionally.
module id_eeprom_i2c_phase_timer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic        o_phase_end
);

    logic [15:0] r_cnt;

    // Load N on a phase boundary, otherwise count down to zero and hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 16'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    // Counter reads N on the first cycle of a phase and 1 on the last
    assign o_phase_end = (r_cnt == 16'd1);

endmodule

// File: rtl/application_selector_id_eeprom_i2c_ctrl.sv
// Byte-level I2C master for the board ID EEPROM, driven by one CMD word per START/byte/ACK/STOP sequence.
// Latency: 2N per START (3N repeated), 18N per byte, 3N per STOP; busy visible the cycle after the CMD write.
// Backpressure: none on the slave port; a CMD write while busy is dropped and flags overrun.
module application_selector_id_eeprom_i2c_ctrl
    import id_eeprom_i2c_pkg::*;
#(
    parameter int DEFAULT_CLKDIV = 250
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_in,
    output logic        irq
);

    state_t      r_state;
    logic        r_busy, r_done, r_rx_nack, r_overrun, r_irq_en;
    logic [7:0]  r_rx, r_tx;
    logic [15:0] r_clkdiv;
    logic [2:0]  r_bitcnt;
    logic        r_scl_oe, r_sda_oe;
    logic        r_stop, r_wr, r_rd, r_ack;

    state_t      w_nstate, w_after_start;
    logic        w_cmd_wr, w_sts_wr, w_div_wr, w_accept;
    logic        w_phase_end, w_adv, w_load, w_done_set;
    logic        w_stop, w_wr, w_rd, w_ack;
    logic        w_scl_nxt, w_sda_nxt;
    logic [7:0]  w_tx_nxt;
    logic        w_unused;

    assign w_cmd_wr = chipselect & ~write_n & (address == REG_CMD);
    assign w_sts_wr = chipselect & ~write_n & (address == REG_STATUS);
    assign w_div_wr = chipselect & ~write_n & (address == REG_CLKDIV);
    assign w_accept = w_cmd_wr & ~r_busy;
    assign w_adv    = (r_state != ST_IDLE) & w_phase_end;

    // On the accept cycle the command fields come straight from the bus, later from the latches
    assign w_stop = w_accept ? writedata[CMD_STOP]  : r_stop;
    assign w_wr   = w_accept ? writedata[CMD_WRITE] : r_wr;
    assign w_rd   = w_accept ? (writedata[CMD_READ] & ~writedata[CMD_WRITE]) : r_rd;
    assign w_ack  = w_accept ? writedata[CMD_ACK]   : r_ack;

    assign w_tx_nxt = w_accept ? writedata[CMD_TX_LSB +: 8] :
                      (w_adv && r_state == ST_BIT_HI) ? {r_tx[6:0], 1'b0} : r_tx;

    assign w_after_start = (w_wr || w_rd) ? ST_BIT_LO :
                           w_stop         ? ST_STOP_A : ST_IDLE;

    assign w_done_set = w_load & (w_nstate == ST_IDLE);

    // Only the defined CMD/STATUS/CLKDIV bits are stored
    assign w_unused = ^{writedata[31:16], writedata[7:5]};

    id_eeprom_i2c_phase_timer u_timer (
        .i_clk       (clk),
        .i_rst_n     (reset_n),
        .i_load      (w_load),
        .i_load_val  (half_period(r_clkdiv)),
        .o_phase_end (w_phase_end)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    // Next state and the line levels to apply on entry to that state
    always_comb begin
        w_nstate  = r_state;
        w_load    = 1'b0;
        w_scl_nxt = r_scl_oe;
        w_sda_nxt = r_sda_oe;
        if (r_state == ST_IDLE) begin
            if (w_accept) begin
                w_load = 1'b1;
                if (writedata[CMD_START]) begin
                    // SCL still held low from a previous command means a repeated start
                    w_nstate = r_scl_oe ? ST_RSTART : ST_START_A;
                end else begin
                    w_nstate = w_after_start;
                end
            end
        end else if (w_phase_end) begin
            w_load = 1'b1;
            case (r_state)
                ST_RSTART:  w_nstate = ST_START_A;
                ST_START_A: w_nstate = ST_START_B;
                ST_START_B: w_nstate = w_after_start;
                ST_BIT_LO:  w_nstate = ST_BIT_HI;
                ST_BIT_HI:  w_nstate = (r_bitcnt == 3'd7) ? ST_ACK_LO : ST_BIT_LO;
                ST_ACK_LO:  w_nstate = ST_ACK_HI;
                ST_ACK_HI:  w_nstate = r_stop ? ST_STOP_A : ST_IDLE;
                ST_STOP_A:  w_nstate = ST_STOP_B;
                ST_STOP_B:  w_nstate = ST_STOP_C;
                default:    w_nstate = ST_IDLE;
            endcase
        end
        if (w_load) begin
            case (w_nstate)
                ST_RSTART:  begin w_scl_nxt = 1'b1; w_sda_nxt = 1'b0; end
                ST_START_A: begin w_scl_nxt = 1'b0; w_sda_nxt = 1'b0; end
                ST_START_B: begin w_scl_nxt = 1'b0; w_sda_nxt = 1'b1; end
                ST_BIT_LO:  begin w_scl_nxt = 1'b1; w_sda_nxt = w_wr & ~w_tx_nxt[7]; end
                ST_BIT_HI:  w_scl_nxt = 1'b0;
                ST_ACK_LO:  begin w_scl_nxt = 1'b1; w_sda_nxt = ~w_wr & ~w_ack; end
                ST_ACK_HI:  w_scl_nxt = 1'b0;
                ST_STOP_A:  begin w_scl_nxt = 1'b1; w_sda_nxt = 1'b1; end
                ST_STOP_B:  begin w_scl_nxt = 1'b0; w_sda_nxt = 1'b1; end
                ST_STOP_C:  begin w_scl_nxt = 1'b0; w_sda_nxt = 1'b0; end
                default: begin
                    // Ending without STOP keeps the bus: SCL low, SDA as it was
                    if (r_state != ST_IDLE && r_state != ST_STOP_C) begin
                        w_scl_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    // Command latches, shift registers, line drivers and the register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rx_nack <= 1'b0;
            r_overrun <= 1'b0;
            r_irq_en  <= 1'b0;
            r_rx      <= 8'd0;
            r_tx      <= 8'd0;
            r_clkdiv  <= 16'(DEFAULT_CLKDIV);
            r_bitcnt  <= 3'd0;
            r_scl_oe  <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_stop    <= 1'b0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_stop   <= w_stop;
                r_wr     <= w_wr;
                r_rd     <= w_rd;
                r_ack    <= w_ack;
                r_bitcnt <= 3'd0;
            end
            r_tx     <= w_tx_nxt;
            r_scl_oe <= w_scl_nxt;
            r_sda_oe <= w_sda_nxt;
            if (w_adv && r_state == ST_BIT_HI) begin
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_rd) begin
                    r_rx <= {r_rx[6:0], sda_in};
                end
            end
            if (w_adv && r_state == ST_ACK_HI) begin
                r_rx_nack <= r_wr ? sda_in : r_ack;
            end
            if (w_done_set) begin
                r_busy <= 1'b0;
            end else if (w_accept) begin
                r_busy <= 1'b1;
            end
            // Completion wins over a coincident STATUS clear
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_sts_wr) begin
                r_done <= 1'b0;
            end
            if (w_cmd_wr && r_busy) begin
                r_overrun <= 1'b1;
            end else if (w_sts_wr) begin
                r_overrun <= 1'b0;
            end
            if (w_sts_wr) begin
                r_irq_en <= writedata[STS_IRQ_EN];
            end
            if (w_div_wr) begin
                r_clkdiv <= writedata[15:0];
            end
        end
    end

    // Zero-wait-state read mux; CMD and the reserved offset read as zero
    always_comb begin
        readdata = 32'd0;
        case (address)
            REG_STATUS: begin
                readdata[STS_BUSY]         = r_busy;
                readdata[STS_DONE]         = r_done;
                readdata[STS_RX_NACK]      = r_rx_nack;
                readdata[STS_OVERRUN]      = r_overrun;
                readdata[STS_IRQ_EN]       = r_irq_en;
                readdata[STS_RX_LSB +: 8]  = r_rx;
            end
            REG_CLKDIV: readdata[15:0] = r_clkdiv;
            default: readdata = 32'd0;
        endcase
    end

    assign scl_oe = r_scl_oe;
    assign sda_oe = r_sda_oe;
    assign irq    = r_done & r_irq_en;

endmodule
